// File: rtl/irq_controller.sv
// External-interrupt front end: synchronises raw lines, counts rising edges per
// source and presents one prioritised, handshaked request to CP0.
module irq_controller #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    parameter int ID_W        = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_irq_src,
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic               i_global_ie,
    input  logic               i_ack,
    input  logic               i_eret,
    output logic               o_irq_req,
    output logic [ID_W-1:0]    o_irq_id,
    output logic [NUM_SRC-1:0] o_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                                state_r;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_r;
    logic [NUM_SRC-1:0]                    prev_r;
    logic [NUM_SRC-1:0][CNT_W-1:0]         cnt_r;
    logic [NUM_SRC-1:0]                    pending_r;
    logic                                  req_r;
    logic [ID_W-1:0]                       id_r;

    logic [NUM_SRC-1:0]                    edge_s;
    logic                                  ack_take_s;
    logic [NUM_SRC-1:0]                    dec_s;
    logic [NUM_SRC-1:0][CNT_W-1:0]         cnt_nxt_s;
    logic [NUM_SRC-1:0]                    pend_nxt_s;
    logic [NUM_SRC-1:0]                    elig_s;
    logic                                  any_elig_s;
    logic [ID_W-1:0]                       low_id_s;

    assign edge_s     = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign ack_take_s = i_ack && (state_r == ST_REQ);
    assign dec_s      = {NUM_SRC{ack_take_s}} & (NUM_SRC'(1) << id_r);

    // Next pending-counter values: edge and ack in the same cycle cancel out.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        pend_nxt_s = {NUM_SRC{1'b0}};
        for (int n = 0; n < NUM_SRC; n++) begin
            if (edge_s[n] && dec_s[n]) begin
                cnt_nxt_s[n] = cnt_r[n];
            end else if (edge_s[n] && (cnt_r[n] != CNT_MAX)) begin
                cnt_nxt_s[n] = cnt_r[n] + CNT_W'(1);
            end else if (dec_s[n] && (cnt_r[n] != CNT_ZERO)) begin
                cnt_nxt_s[n] = cnt_r[n] - CNT_W'(1);
            end else begin
                cnt_nxt_s[n] = cnt_r[n];
            end
            pend_nxt_s[n] = (cnt_nxt_s[n] != CNT_ZERO);
        end
    end

    // Eligibility and fixed priority, lowest index wins.
    always_comb begin
        low_id_s = {ID_W{1'b0}};
        for (int n = 0; n < NUM_SRC; n++) begin
            elig_s[n] = (cnt_r[n] != CNT_ZERO) && i_mask[n] && i_global_ie;
        end
        for (int n = NUM_SRC - 1; n >= 0; n--) begin
            low_id_s = elig_s[n] ? ID_W'(n) : low_id_s;
        end
        any_elig_s = |elig_s;
    end

    // Synchroniser chain, edge history and pending counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r    <= '0;
            prev_r    <= {NUM_SRC{1'b0}};
            cnt_r     <= '0;
            pending_r <= {NUM_SRC{1'b0}};
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], i_irq_src};
            prev_r    <= sync_r[SYNC_STAGES-1];
            cnt_r     <= cnt_nxt_s;
            pending_r <= pend_nxt_s;
        end
    end

    // Request handshake FSM with registered request and id.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            id_r    <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_elig_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        id_r    <= low_id_s;
                    end else begin
                        req_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (i_ack) begin
                        state_r <= ST_SERVICE;
                        req_r   <= 1'b0;
                    end else if (!i_global_ie || !i_mask[id_r]) begin
                        // Withdrawn; the counter keeps the event for later.
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    req_r <= 1'b0;
                    if (i_eret) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SERVICE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_irq_req = req_r;
    assign o_irq_id  = id_r;
    assign o_pending = pending_r;

endmodule
